// File: rtl/hash_pkg.sv
// hash_pkg: shared types and constants for the hash round sequencer
// Contents: hash_state_t FSM encoding, IV bytes, LEN_W, ROUNDS, c_byte_t length-byte view.
package hash_pkg;
    localparam int LEN_W = 64;
    localparam int ROUNDS = 8;
    localparam logic [0:7][7:0] IV = {8'h6a, 8'h09, 8'he6, 8'h67, 8'hbb, 8'h67, 8'hae, 8'h85};
    typedef enum logic [2:0] {IDLE, INIT, WAIT_BYTE, ROUND, FINAL, DONE} hash_state_t;
    // element [0] is the least significant byte of the length counter
    typedef logic [0:7][7:0] c_byte_t;
endpackage

// File: rtl/hash_len_counter.sv
// hash_len_counter: message byte-length counter C, presented as eight bytes
// Ports: clk, reset (async, active-high), clr (zero C), inc (count one byte), c_byte (C split, [0] = LSB).
// Build option HASH_LEN_SAT_EN: C saturates at all-ones and sets the sticky len_sat flag;
// otherwise C wraps modulo 2^64.
module hash_len_counter
    import hash_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    clr,
    input  logic    inc,
    output c_byte_t c_byte
);
    logic [LEN_W-1:0] c;
`ifdef HASH_LEN_SAT_EN
    logic len_sat;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c       <= '0;
            len_sat <= 1'b0;
        end else if (clr) begin
            c       <= '0;
            len_sat <= 1'b0;
        end else if (inc) begin
            if (&c) len_sat <= 1'b1;
            else c <= c + 1'b1;
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) c <= '0;
        else if (clr) c <= '0;
        else if (inc) c <= c + 1'b1;
    end
`endif
    always_comb begin
        c_byte = '0;
        for (int k = 0; k < 8; k++) c_byte[k] = c[8*k +: 8];
    end
endmodule

// File: rtl/hash_round_ctrl.sv
// hash_round_ctrl: sequencer driving the 8-byte hash datapath through update and final rounds
// Ports: clk, reset (async, active-high); msg_valid/msg_byte/msg_last/msg_ready byte stream in;
// init_H, update_H, i_count, sel_final, byte_out, C_byte datapath controls;
// digest_valid/digest_ready digest handoff; busy = not idle.
// Build option HASH_LEN_SAT_EN (in hash_len_counter): saturating length counter.
module hash_round_ctrl
    import hash_pkg::*;
#(
    parameter int FINAL_PASSES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       msg_valid,
    input  logic [7:0] msg_byte,
    input  logic       msg_last,
    output logic       msg_ready,
    output logic       init_H,
    output logic       update_H,
    output logic [2:0] i_count,
    output logic       sel_final,
    output logic [7:0] byte_out,
    output c_byte_t    C_byte,
    output logic       digest_valid,
    input  logic       digest_ready,
    output logic       busy
);
    hash_state_t state, state_nx;
    logic [1:0] pass;
    logic last_q;
    logic accept;
    logic last_round;
    assign accept     = (state == WAIT_BYTE) && msg_valid;
    assign last_round = (i_count == 3'(ROUNDS - 1));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            i_count  <= '0;
            pass     <= '0;
            byte_out <= '0;
            last_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                byte_out <= msg_byte;
                last_q   <= msg_last;
                i_count  <= '0;
            end
            // i_count wraps 7->0 on its own, so it reads 0 again when a round block ends
            if (state == ROUND || state == FINAL) i_count <= i_count + 3'd1;
            if (state == ROUND && last_round) pass <= '0;
            if (state == FINAL && last_round) pass <= pass + 2'd1;
        end
    end
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      state_nx = msg_valid ? INIT : IDLE;
            INIT:      state_nx = WAIT_BYTE;
            WAIT_BYTE: state_nx = msg_valid ? ROUND : WAIT_BYTE;
            ROUND:     state_nx = last_round ? (last_q ? FINAL : WAIT_BYTE) : ROUND;
            FINAL:     state_nx = (last_round && pass == 2'(FINAL_PASSES - 1)) ? DONE : FINAL;
            DONE:      state_nx = digest_ready ? IDLE : DONE;
            default:   state_nx = IDLE;
        endcase
    end
    assign msg_ready    = (state == WAIT_BYTE);
    assign init_H       = (state == INIT);
    assign update_H     = (state == ROUND) || (state == FINAL);
    assign sel_final    = (state == FINAL);
    assign digest_valid = (state == DONE);
    assign busy         = (state != IDLE);
    hash_len_counter u_len (
        .clk    (clk),
        .reset  (reset),
        .clr    (state == INIT),
        .inc    (accept),
        .c_byte (C_byte)
    );
endmodule
